if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 146 ++++++++++++++
 tb/tb_if_id_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_id_buffer : fetch/decode skid queue pairing fetch metadata with imem data |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+

package if_id_buffer_pkg;
    typedef struct packed {
        logic [31:0] pc_s;
        logic        valid_s;
        logic [63:0] order_s;
    } if_id_stage_reg_t;
endpackage

module if_id_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  if_id_buffer_pkg::if_id_stage_reg_t  if_id_reg,
    input  logic [31:0]                         imem_rdata,
    input  logic                                imem_resp,
    input  logic                                id_stall,
    input  logic                                flush,
    output logic                                if_stall,
    output logic                                id_valid,
    output logic [31:0]                         id_pc,
    output logic [63:0]                         id_order,
    output logic [31:0]                         id_inst
);

    localparam int          CNT_W    = $clog2(DEPTH + 1);
    localparam int          PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [63:0]      pend_order_q, pend_order_d;
    logic             drop_q, drop_d;

    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      pc_mem_d    [DEPTH];
    logic [63:0]      order_mem_q [DEPTH];
    logic [63:0]      order_mem_d [DEPTH];
    logic [31:0]      inst_mem_q  [DEPTH];
    logic [31:0]      inst_mem_d  [DEPTH];

    logic             pop;
    logic             push;
    logic             accept;
    logic [CNT_W:0]   free;
    logic [CNT_W:0]   need;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign id_valid = (count_q != '0);
    assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
    assign id_order = id_valid ? order_mem_q[rd_ptr_q] : 64'h0;
    assign id_inst  = id_valid ? inst_mem_q[rd_ptr_q]  : NOP_INST;

    // A pending response already owns one slot, so a new request needs a second.
    assign pop      = id_valid & ~id_stall;
    assign free     = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(pop);
    assign need     = (CNT_W+1)'(pend_valid_q) + (CNT_W+1)'(1);
    assign if_stall = drop_q | (pend_valid_q & ~imem_resp) | (free < need);
    assign accept   = if_id_reg.valid_s & ~if_stall & ~flush;
    assign push     = imem_resp & pend_valid_q & ~drop_q & ~flush;

    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        pend_order_d = pend_order_q;
        drop_d       = drop_q;
        pc_mem_d     = pc_mem_q;
        order_mem_d  = order_mem_q;
        inst_mem_d   = inst_mem_q;

        if (flush) begin
            count_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            pend_valid_d = 1'b0;
            drop_d       = pend_valid_q & ~imem_resp;
        end else begin
            if (drop_q && imem_resp) begin
                drop_d = 1'b0;
            end
            if (push) begin
                pc_mem_d[wr_ptr_q]    = pend_pc_q;
                order_mem_d[wr_ptr_q] = pend_order_q;
                inst_mem_d[wr_ptr_q]  = imem_rdata;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (accept) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = if_id_reg.pc_s;
                pend_order_d = if_id_reg.order_s;
            end else if (push) begin
                pend_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pend_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pend_valid_q <= pend_valid_d;
            drop_q       <= drop_d;
            assert (!(push && !pop && count_q == CNT_W'(DEPTH)))
                else $error("if_id_buffer: push into full queue");
            assert (!(imem_resp && !pend_valid_q && !drop_q && !flush))
                else $warning("if_id_buffer: imem_resp with no request outstanding ignored");
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        pend_pc_q    <= pend_pc_d;
        pend_order_q <= pend_order_d;
        pc_mem_q     <= pc_mem_d;
        order_mem_q  <= order_mem_d;
        inst_mem_q   <= inst_mem_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_if_id_buffer : directed self-checking bench for if_id_buffer               |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_if_id_buffer;
    import if_id_buffer_pkg::*;

    localparam logic [31:0] PC_BASE = 32'h1eceb000;

    logic             clk = 1'b0;
    logic             rst_n;
    if_id_stage_reg_t if_id_reg;
    logic [31:0]      imem_rdata;
    logic             imem_resp;
    logic             id_stall;
    logic             flush;
    logic             if_stall;
    logic             id_valid;
    logic [31:0]      id_pc;
    logic [63:0]      id_order;
    logic [31:0]      id_inst;

    int checks = 0;
    int errors = 0;

    if_id_buffer #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_id_reg  (if_id_reg),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .id_stall   (id_stall),
        .flush      (flush),
        .if_stall   (if_stall),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_order   (id_order),
        .id_inst    (id_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    // Request i carries pc = base + 4*i and order = i.
    task automatic drive(input logic v, input int ri, input logic r, input logic [31:0] data,
                         input logic st, input logic fl);
        if_id_reg.valid_s = v;
        if_id_reg.pc_s    = PC_BASE + 32'(4 * ri);
        if_id_reg.order_s = 64'(ri);
        imem_resp         = r;
        imem_rdata        = data;
        id_stall          = st;
        flush             = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input int i);
        chk({tag, ".id_valid"}, 64'(id_valid), 64'd1);
        chk({tag, ".id_pc"},    64'(id_pc),    64'(PC_BASE + 32'(4 * i)));
        chk({tag, ".id_order"}, id_order,      64'(i));
        chk({tag, ".id_inst"},  64'(id_inst),  64'(inst_of(i)));
    endtask

    task automatic empty(input string tag);
        chk({tag, ".id_valid"}, 64'(id_valid), 64'd0);
        chk({tag, ".id_pc"},    64'(id_pc),    64'd0);
        chk({tag, ".id_order"}, id_order,      64'd0);
        chk({tag, ".id_inst"},  64'(id_inst),  64'h13);
    endtask

    task automatic stall_is(input string tag, input logic exp);
        chk({tag, ".if_stall"}, 64'(if_stall), 64'(exp));
    endtask

    initial begin
        // Reset held with busy inputs
        rst_n = 1'b0;
        drive(1'b1, 0, 1'b1, inst_of(0), 1'b0, 1'b0);
        tick;
        tick;
        empty("reset");
        stall_is("reset", 1'b0);

        // Streaming: one request per cycle, response one cycle later
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, c, (c >= 1), inst_of(c - 1), 1'b0, 1'b0);
            stall_is("stream", 1'b0);
            if (c >= 2) head("stream", c - 2);
            else        empty("stream");
            tick;
        end

        // Backpressure: decode stalls five cycles
        drive(1'b1, 6, 1'b1, inst_of(5), 1'b1, 1'b0);
        stall_is("bp0", 1'b1);
        head("bp0", 4);
        tick;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 6, 1'b0, 32'h0, 1'b1, 1'b0);
            stall_is("bp_full", 1'b1);
            head("bp_full", 4);
            tick;
        end
        drive(1'b1, 6, 1'b0, 32'h0, 1'b0, 1'b0);
        stall_is("bp_rel", 1'b0);
        head("bp_rel", 4);
        tick;
        // Push and pop together with one entry queued
        drive(1'b1, 7, 1'b1, inst_of(6), 1'b0, 1'b0);
        stall_is("pushpop1", 1'b0);
        head("pushpop1", 5);
        tick;
        drive(1'b1, 8, 1'b1, inst_of(7), 1'b0, 1'b0);
        stall_is("pushpop2", 1'b0);
        head("pushpop2", 6);
        tick;
        drive(1'b0, 0, 1'b1, inst_of(8), 1'b0, 1'b0);
        stall_is("drain", 1'b0);
        head("drain", 7);
        tick;

        // Slow memory: three cycles without a response
        drive(1'b1, 9, 1'b0, 32'h0, 1'b0, 1'b0);
        stall_is("slow_req", 1'b0);
        head("slow_req", 8);
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 10, 1'b0, 32'h0, 1'b0, 1'b0);
            stall_is("slow_wait", 1'b1);
            empty("slow_wait");
            tick;
        end
        drive(1'b1, 10, 1'b1, inst_of(9), 1'b0, 1'b0);
        stall_is("slow_resp", 1'b0);
        empty("slow_resp");
        tick;
        drive(1'b0, 0, 1'b1, inst_of(10), 1'b0, 1'b0);
        stall_is("slow_head", 1'b0);
        head("slow_head", 9);
        tick;
        drive(1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        head("slow_next", 10);
        tick;

        // Flush with a request outstanding; stale response must vanish
        drive(1'b1, 11, 1'b0, 32'h0, 1'b0, 1'b0);
        stall_is("fl_req", 1'b0);
        empty("fl_req");
        tick;
        drive(1'b1, 12, 1'b0, 32'h0, 1'b0, 1'b1);
        stall_is("fl_cyc", 1'b1);
        tick;
        drive(1'b1, 12, 1'b0, 32'h0, 1'b0, 1'b0);
        stall_is("fl_drop", 1'b1);
        empty("fl_drop");
        tick;
        drive(1'b1, 12, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        stall_is("fl_stale", 1'b1);
        empty("fl_stale");
        tick;
        drive(1'b1, 12, 1'b0, 32'h0, 1'b0, 1'b0);
        stall_is("fl_after", 1'b0);
        empty("fl_after");
        tick;
        drive(1'b0, 0, 1'b1, inst_of(12), 1'b0, 1'b0);
        stall_is("fl_resp", 1'b0);
        empty("fl_resp");
        tick;
        drive(1'b1, 13, 1'b0, 32'h0, 1'b1, 1'b0);
        stall_is("fl_head", 1'b0);
        head("fl_head", 12);
        tick;

        // Reset with an entry queued and a request outstanding
        rst_n = 1'b0;
        drive(1'b1, 14, 1'b0, 32'h0, 1'b1, 1'b0);
        tick;
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        stall_is("rst_mid", 1'b0);
        empty("rst_mid");
        tick;
        drive(1'b1, 14, 1'b0, 32'h0, 1'b0, 1'b0);
        stall_is("rst_late", 1'b0);
        empty("rst_late");
        tick;
        drive(1'b0, 0, 1'b1, inst_of(14), 1'b0, 1'b0);
        empty("rst_nobypass");
        tick;
        drive(1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        head("rst_resume", 14);
        tick;

        // Flush discards a buffered entry
        drive(1'b1, 15, 1'b0, 32'h0, 1'b0, 1'b0);
        tick;
        drive(1'b0, 0, 1'b1, inst_of(15), 1'b0, 1'b0);
        tick;
        drive(1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b1);
        head("fl_buf", 15);
        tick;
        drive(1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        empty("fl_buf_after");
        stall_is("fl_buf_after", 1'b0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
